// File: rtl/ram_arbiter.sv
// Two-port arbiter for the single-port data RAM: fetch and load/store share one
// RAM strobe per cycle. Read data is routed back to whichever port issued the read.
module ram_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int MEM_W      = 16,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [MEM_W-1:0]  if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [MEM_W-1:0]  mem_wdata,
    output logic              mem_gnt,
    output logic              mem_rvalid,
    output logic [MEM_W-1:0]  mem_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_read,
    output logic              ram_write,
    output logic [MEM_W-1:0]  ram_wdata,
    output logic              ram_wdata_oe,
    input  logic [MEM_W-1:0]  ram_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

    localparam logic [2:0] STARVE_LIM = STARVE_MAX[2:0];

    state_t            r_state;
    state_t            w_next;
    logic [2:0]        r_starve_cnt;
    logic              r_owner;
    logic              w_bubble;
    logic              w_mem_elig;
    logic              w_fetch_pri;
    logic              w_if_gnt;
    logic              w_mem_gnt;
    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_ram_read;
    logic              r_ram_write;
    logic [MEM_W-1:0]  r_ram_wdata;
    logic              r_if_rvalid;
    logic              r_mem_rvalid;
    logic [MEM_W-1:0]  r_if_rdata;
    logic [MEM_W-1:0]  r_mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = S_IDLE;
        if (w_mem_gnt)     w_next = mem_we ? S_WR : S_RD;
        else if (w_if_gnt) w_next = S_RD;
    end

    // A write arriving while a read is on the bus stalls everyone for one cycle
    // so ram_rdata and ram_wdata never share the bus.
    always_comb begin
        w_bubble    = (r_state == S_RD) && mem_req && mem_we;
        w_mem_elig  = mem_req && !w_bubble;
        w_fetch_pri = (r_starve_cnt == STARVE_LIM);
        w_if_gnt    = !rst && if_req && !w_bubble && (!w_mem_elig || w_fetch_pri);
        w_mem_gnt   = !rst && w_mem_elig && !(if_req && w_fetch_pri);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= 3'd0;
        end else if (w_if_gnt) begin
            r_starve_cnt <= 3'd0;
        end else if (if_req && (r_starve_cnt != STARVE_LIM)) begin
            r_starve_cnt <= r_starve_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ram_addr  <= '0;
            r_ram_read  <= 1'b0;
            r_ram_write <= 1'b0;
            r_ram_wdata <= '0;
            r_owner     <= 1'b0;
        end else begin
            r_ram_read  <= (w_next == S_RD);
            r_ram_write <= (w_next == S_WR);
            if (w_mem_gnt) begin
                r_ram_addr <= mem_addr;
                if (mem_we) r_ram_wdata <= mem_wdata;
                else        r_owner     <= 1'b1;
            end else if (w_if_gnt) begin
                r_ram_addr <= if_addr;
                r_owner    <= 1'b0;
            end
        end
    end

    // r_owner may be overwritten on the same edge by a pipelined read, so the
    // return is steered by the value it held during the RD cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_rvalid  <= 1'b0;
            r_mem_rvalid <= 1'b0;
            r_if_rdata   <= '0;
            r_mem_rdata  <= '0;
        end else begin
            r_if_rvalid  <= r_ram_read && !r_owner;
            r_mem_rvalid <= r_ram_read && r_owner;
            if (r_if_rvalid)  r_if_rdata  <= ram_rdata;
            if (r_mem_rvalid) r_mem_rdata <= ram_rdata;
        end
    end

    assign if_gnt       = w_if_gnt;
    assign mem_gnt      = w_mem_gnt;
    assign ram_addr     = r_ram_addr;
    assign ram_read     = r_ram_read;
    assign ram_write    = r_ram_write;
    assign ram_wdata    = r_ram_wdata;
    assign ram_wdata_oe = r_ram_write;
    assign if_rvalid    = r_if_rvalid;
    assign mem_rvalid   = r_mem_rvalid;
    assign if_rdata     = r_if_rvalid  ? ram_rdata : r_if_rdata;
    assign mem_rdata    = r_mem_rvalid ? ram_rdata : r_mem_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: cycle-by-cycle vector table plus a reset-mid-read
// sequence, against a behavioural single-port RAM.
module tb_ram_arbiter;

    logic        clk, rst;
    logic        if_req, mem_req, mem_we;
    logic [15:0] if_addr, mem_addr, mem_wdata;
    logic        if_gnt, if_rvalid, mem_gnt, mem_rvalid;
    logic [15:0] if_rdata, mem_rdata, ram_addr, ram_wdata, ram_rdata;
    logic        ram_read, ram_write, ram_wdata_oe;

    logic [15:0] mem [0:65535];

    int n_cmp = 0;
    int n_bad = 0;
    int row_idx = -1;

    typedef struct {
        logic ir; logic [15:0] ia;
        logic mr; logic mw; logic [15:0] ma; logic [15:0] md;
        logic ig; logic mg; logic rr; logic rw;
        logic [15:0] ra; logic [15:0] wd;
        logic iv; logic [15:0] id;
        logic mv; logic [15:0] mo;
        logic [2:0] st;
    } vec_t;

    vec_t vq[$];

    ram_arbiter #(.ADDR_W(16), .MEM_W(16), .STARVE_MAX(3)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .ram_addr(ram_addr), .ram_read(ram_read), .ram_write(ram_write),
        .ram_wdata(ram_wdata), .ram_wdata_oe(ram_wdata_oe), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: read data appears the cycle after ram_read.
    always @(posedge clk) begin
        if (ram_write) mem[ram_addr] <= ram_wdata;
        if (ram_read)  ram_rdata <= mem[ram_addr];
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (row %0d): got %b want %b", name, row_idx, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (row %0d): got %h want %h", name, row_idx, act, exp);
        end
    endtask

    task automatic add(input int ir, ia, mr, mw, ma, md,
                       input int ig, mg, rr, rw, ra, wd, iv, id, mv, mo, st);
        vec_t v;
        v.ir = ir[0]; v.ia = ia[15:0]; v.mr = mr[0]; v.mw = mw[0];
        v.ma = ma[15:0]; v.md = md[15:0];
        v.ig = ig[0]; v.mg = mg[0]; v.rr = rr[0]; v.rw = rw[0];
        v.ra = ra[15:0]; v.wd = wd[15:0];
        v.iv = iv[0]; v.id = id[15:0]; v.mv = mv[0]; v.mo = mo[15:0];
        v.st = st[2:0];
        vq.push_back(v);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk1({tag, ".if_gnt"}, if_gnt, 1'b0);
        chk1({tag, ".mem_gnt"}, mem_gnt, 1'b0);
        chk1({tag, ".ram_read"}, ram_read, 1'b0);
        chk1({tag, ".ram_write"}, ram_write, 1'b0);
        chk1({tag, ".ram_wdata_oe"}, ram_wdata_oe, 1'b0);
        chk16({tag, ".ram_addr"}, ram_addr, 16'h0000);
        chk16({tag, ".ram_wdata"}, ram_wdata, 16'h0000);
        chk1({tag, ".if_rvalid"}, if_rvalid, 1'b0);
        chk16({tag, ".if_rdata"}, if_rdata, 16'h0000);
        chk1({tag, ".mem_rvalid"}, mem_rvalid, 1'b0);
        chk16({tag, ".mem_rdata"}, mem_rdata, 16'h0000);
        chk16({tag, ".starve_cnt"}, {13'd0, dut.r_starve_cnt}, 16'h0000);
        chk1({tag, ".owner"}, dut.r_owner, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i + 'h1000);
        mem[16'h0040] = 16'hBEEF;
        ram_rdata = 16'h0;
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;

        //   ir ia      mr mw ma      md      | ig mg rr rw ra      wd      iv id      mv mo      st
        // single fetch
        add(1, 'h0040, 0, 0, 'h0000, 'h0000,  1, 0, 0, 0, 'h0000, 'h0000, 0, 'h0000, 0, 'h0000, 0);
        add(0, 'h0000, 0, 0, 'h0000, 'h0000,  0, 0, 1, 0, 'h0040, 'h0000, 0, 'h0000, 0, 'h0000, 0);
        add(0, 'h0000, 0, 0, 'h0000, 'h0000,  0, 0, 0, 0, 'h0040, 'h0000, 1, 'hBEEF, 0, 'h0000, 0);
        add(0, 'h0000, 0, 0, 'h0000, 'h0000,  0, 0, 0, 0, 'h0040, 'h0000, 0, 'hBEEF, 0, 'h0000, 0);
        // both requesting: starvation override on the 4th opportunity
        add(1, 'h0200, 1, 0, 'h0100, 'h0000,  0, 1, 0, 0, 'h0040, 'h0000, 0, 'hBEEF, 0, 'h0000, 0);
        add(1, 'h0200, 1, 0, 'h0101, 'h0000,  0, 1, 1, 0, 'h0100, 'h0000, 0, 'hBEEF, 0, 'h0000, 1);
        add(1, 'h0200, 1, 0, 'h0102, 'h0000,  0, 1, 1, 0, 'h0101, 'h0000, 0, 'hBEEF, 1, 'h1100, 2);
        add(1, 'h0200, 1, 0, 'h0103, 'h0000,  1, 0, 1, 0, 'h0102, 'h0000, 0, 'hBEEF, 1, 'h1101, 3);
        add(1, 'h0201, 1, 0, 'h0103, 'h0000,  0, 1, 1, 0, 'h0200, 'h0000, 0, 'hBEEF, 1, 'h1102, 0);
        add(1, 'h0201, 0, 0, 'h0000, 'h0000,  1, 0, 1, 0, 'h0103, 'h0000, 1, 'h1200, 0, 'h1102, 1);
        add(0, 'h0000, 0, 0, 'h0000, 'h0000,  0, 0, 1, 0, 'h0201, 'h0000, 0, 'h1200, 1, 'h1103, 0);
        add(0, 'h0000, 0, 0, 'h0000, 'h0000,  0, 0, 0, 0, 'h0201, 'h0000, 1, 'h1201, 0, 'h1103, 0);
        add(0, 'h0000, 0, 0, 'h0000, 'h0000,  0, 0, 0, 0, 'h0201, 'h0000, 0, 'h1201, 0, 'h1103, 0);
        // store then load, no bubble after a write
        add(0, 'h0000, 1, 1, 'h0005, 'h1234,  0, 1, 0, 0, 'h0201, 'h0000, 0, 'h1201, 0, 'h1103, 0);
        add(0, 'h0000, 1, 0, 'h0005, 'h0000,  0, 1, 0, 1, 'h0005, 'h1234, 0, 'h1201, 0, 'h1103, 0);
        add(0, 'h0000, 0, 0, 'h0000, 'h0000,  0, 0, 1, 0, 'h0005, 'h1234, 0, 'h1201, 0, 'h1103, 0);
        add(0, 'h0000, 0, 0, 'h0000, 'h0000,  0, 0, 0, 0, 'h0005, 'h1234, 0, 'h1201, 1, 'h1234, 0);
        // read then write with fetch streaming: bubble in RD
        add(1, 'h0300, 0, 0, 'h0000, 'h0000,  1, 0, 0, 0, 'h0005, 'h1234, 0, 'h1201, 0, 'h1234, 0);
        add(1, 'h0301, 1, 1, 'h0010, 'hCAFE,  0, 0, 1, 0, 'h0300, 'h1234, 0, 'h1201, 0, 'h1234, 0);
        add(1, 'h0301, 1, 1, 'h0010, 'hCAFE,  0, 1, 0, 0, 'h0300, 'h1234, 1, 'h1300, 0, 'h1234, 1);
        add(1, 'h0301, 0, 0, 'h0000, 'h0000,  1, 0, 0, 1, 'h0010, 'hCAFE, 0, 'h1300, 0, 'h1234, 2);
        add(0, 'h0000, 0, 0, 'h0000, 'h0000,  0, 0, 1, 0, 'h0301, 'hCAFE, 0, 'h1300, 0, 'h1234, 0);
        add(0, 'h0000, 0, 0, 'h0000, 'h0000,  0, 0, 0, 0, 'h0301, 'hCAFE, 1, 'h1301, 0, 'h1234, 0);
        // four pipelined fetch reads
        add(1, 'h0000, 0, 0, 'h0000, 'h0000,  1, 0, 0, 0, 'h0301, 'hCAFE, 0, 'h1301, 0, 'h1234, 0);
        add(1, 'h0001, 0, 0, 'h0000, 'h0000,  1, 0, 1, 0, 'h0000, 'hCAFE, 0, 'h1301, 0, 'h1234, 0);
        add(1, 'h0002, 0, 0, 'h0000, 'h0000,  1, 0, 1, 0, 'h0001, 'hCAFE, 1, 'h1000, 0, 'h1234, 0);
        add(1, 'h0003, 0, 0, 'h0000, 'h0000,  1, 0, 1, 0, 'h0002, 'hCAFE, 1, 'h1001, 0, 'h1234, 0);
        add(0, 'h0000, 0, 0, 'h0000, 'h0000,  0, 0, 1, 0, 'h0003, 'hCAFE, 1, 'h1002, 0, 'h1234, 0);
        add(0, 'h0000, 0, 0, 'h0000, 'h0000,  0, 0, 0, 0, 'h0003, 'hCAFE, 1, 'h1003, 0, 'h1234, 0);
        add(0, 'h0000, 0, 0, 'h0000, 'h0000,  0, 0, 0, 0, 'h0003, 'hCAFE, 0, 'h1003, 0, 'h1234, 0);

        repeat (2) @(posedge clk);
        #2;
        chk_idle_outputs("reset");
        rst = 1'b0;

        foreach (vq[k]) begin
            row_idx = k;
            @(posedge clk);
            #1;
            if_req = vq[k].ir;  if_addr = vq[k].ia;
            mem_req = vq[k].mr; mem_we = vq[k].mw;
            mem_addr = vq[k].ma; mem_wdata = vq[k].md;
            #1;
            chk1("if_gnt", if_gnt, vq[k].ig);
            chk1("mem_gnt", mem_gnt, vq[k].mg);
            chk1("gnt_excl", if_gnt & mem_gnt, 1'b0);
            chk1("ram_read", ram_read, vq[k].rr);
            chk1("ram_write", ram_write, vq[k].rw);
            chk1("ram_wdata_oe", ram_wdata_oe, vq[k].rw);
            chk16("ram_addr", ram_addr, vq[k].ra);
            chk16("ram_wdata", ram_wdata, vq[k].wd);
            chk1("if_rvalid", if_rvalid, vq[k].iv);
            chk16("if_rdata", if_rdata, vq[k].id);
            chk1("mem_rvalid", mem_rvalid, vq[k].mv);
            chk16("mem_rdata", mem_rdata, vq[k].mo);
            chk16("starve_cnt", {13'd0, dut.r_starve_cnt}, {13'd0, vq[k].st});
        end

        // reset in the middle of a data-port read of 0x0010
        row_idx = -2;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 16'h0400;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h0010;
        #1;
        chk1("rr.mem_gnt", mem_gnt, 1'b1);
        chk1("rr.if_gnt", if_gnt, 1'b0);
        @(posedge clk); #1;
        if_req = 1'b0; mem_req = 1'b0;
        #1;
        chk1("rr.ram_read", ram_read, 1'b1);
        chk16("rr.ram_addr", ram_addr, 16'h0010);
        chk16("rr.starve_cnt", {13'd0, dut.r_starve_cnt}, 16'h0001);
        chk1("rr.owner", dut.r_owner, 1'b1);
        rst = 1'b1;
        if_req = 1'b1;
        #1;
        chk_idle_outputs("rr.inrst");
        @(posedge clk); #2;
        if_req = 1'b0;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #2;
            chk1("rr.if_rvalid", if_rvalid, 1'b0);
            chk1("rr.mem_rvalid", mem_rvalid, 1'b0);
            chk16("rr.mem_rdata", mem_rdata, 16'h0000);
            chk1("rr.ram_read", ram_read, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester controller for the single-port data RAM of the 16-bit processor. It shares the RAM between the instruction-fetch unit and the load/store unit, and sequences each access into one RAM read or write strobe. Read data is returned to the requester that issued the read. A bounded-starvation rule stops back-to-back data traffic from locking out fetch.

## Interface
- ADDR_W, 16: RAM address width.
- MEM_W, 16: RAM word width.
- STARVE_MAX, 3: lost arbitration opportunities after which fetch overrides data-port priority (1..7).

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch read request
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request accepted this cycle (combinational)
- if_rvalid  out  1  fetch read data valid (registered)
- if_rdata  out  MEM_W  fetch read data
- mem_req  in  1  load/store request
- mem_we  in  1  1 = write, 0 = read
- mem_addr  in  ADDR_W  load/store address
- mem_wdata  in  MEM_W  store data
- mem_gnt  out  1  load/store request accepted this cycle (combinational)
- mem_rvalid  out  1  load read data valid (registered)
- mem_rdata  out  MEM_W  load read data
- ram_addr  out  ADDR_W  RAM address
- ram_read  out  1  RAM read strobe
- ram_write  out  1  RAM write strobe
- ram_wdata  out  MEM_W  RAM write data
- ram_wdata_oe  out  1  drive enable for the RAM data bus, equal to ram_write
- ram_rdata  in  MEM_W  RAM read data, valid the cycle after ram_read

## Operation
- States:
  - IDLE: no access.
  - RD: ram_read high.
  - WR: ram_write high.
- All ram_* outputs come from registers loaded on the accept edge.
- Accept opportunity: every cycle in IDLE, RD or WR. An accepted request is latched on that edge. The next state is RD or WR according to the type of the accepted request.
- Eligibility:
  - if_req is always eligible.
  - A mem_req read is always eligible.
  - A mem_req write is not eligible in RD, because of bus turnaround: ram_rdata is returning in the next cycle.
- Write-pending bubble: in RD with mem_req && mem_we, nothing is accepted and the next state is IDLE. The write is then accepted from IDLE.
- Priority when both requesters are eligible:
  - Data port wins by default.
  - Fetch wins if starve_cnt == STARVE_MAX.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, on each accept opportunity with if_req high and if_gnt low.
  - Clears on if_gnt.
  - Holds otherwise.
- No accept (no eligible request, or bubble): next state is IDLE.
- Owner bit: latched on each read accept (0 = fetch, 1 = data).
- Read return:
  - The cycle after RD, rvalid is set for the latched owner only.
  - The owner's rdata equals ram_rdata.
  - The non-owner's rdata holds its last value.
- Writes produce no response. mem_gnt is the completion indication.
- Requesters hold req/addr/wdata stable until gnt. They may change them in the cycle after gnt.
- Reset (any time):
  - State IDLE, all outputs 0, starve_cnt 0, owner 0.
  - An in-flight read is discarded: no rvalid after reset.

## Timing
- gnt is combinational from req, state and starve_cnt. It is never high for both ports in the same cycle.
- Read: gnt in cycle C, ram_read in C+1, rvalid and rdata in C+2. Latency from gnt to data is 2 cycles.
- Write: gnt in cycle C, ram_write, ram_wdata_oe and ram_wdata in C+1.
- Peak throughput is one read per cycle (pipelined: a new read is accepted during RD).
- Read followed by write costs one bubble cycle: RD, IDLE, WR.
- Write followed by read needs no bubble.
- With RD followed by RD, rvalid for the first read coincides with ram_read for the second. The owner of each read is tracked per accepted read.

## Test plan
- Reset mid-read: read to 0x0010 granted, rst pulses during RD -> all outputs 0 at once, no rvalid after deassert, starve_cnt 0.
- Single fetch: RAM[0x0040]=0xBEEF, if_req with if_addr=0x0040 for one cycle -> if_gnt in C, ram_read with ram_addr=0x0040 in C+1, if_rvalid=1 and if_rdata=0xBEEF in C+2, mem_rvalid stays 0.
- Simultaneous requests, STARVE_MAX=3: if_req held, mem_req read held for 5 cycles -> mem_gnt for 3 cycles, if_gnt on the 4th, mem_gnt on the 5th; starve_cnt goes 1,2,3,0,1.
- Store then load: mem write 0x1234 to 0x0005 granted in C, then mem read of 0x0005 -> ram_write and ram_wdata_oe in C+1 with ram_wdata=0x1234, read granted in C+1, mem_rdata=0x1234 with mem_rvalid in C+3.
- Read followed by write with fetch streaming: fetch read in RD, mem write pending -> IDLE bubble, then WR, with no if_gnt and no mem_gnt during the RD cycle; pending fetch is granted again the cycle after mem_gnt.
- Pipelined reads: 4 fetch reads to 0x0000..0x0003 back to back -> ram_read high for 4 consecutive cycles, if_rvalid high for 4 consecutive cycles starting 2 cycles after the first gnt, data in order.
